// File: rtl/jtag_axi_pkg.sv
// Shared types and widths for the JTAG-to-AXI data registers.
// Packed structs list fields MSB first, so the last field sits at bit 0.
package jtag_axi_pkg;

    localparam int JTAG_INFO_DR_W   = 73;
    localparam int JTAG_STATUS_DR_W = 36;

    // Transaction status reported by the dispatch stage.
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RUNNING    = 4'd1,
        OKAY       = 4'd2,
        EXOKAY     = 4'd3,
        SLVERR     = 4'd4,
        DECERR     = 4'd5,
        TIMEOUT_AW = 4'd6,
        TIMEOUT_AR = 4'd7,
        TIMEOUT_W  = 4'd8,
        TIMEOUT_B  = 4'd9,
        TIMEOUT_R  = 4'd10
    } axi_jtag_status_e;

    // Control bits: start at bit 0, txn_type (1 = write) at bit 1, size at bits 4:2.
    typedef struct packed {
        logic [2:0] size;
        logic       txn_type;
        logic       start;
    } s_axi_jtag_ctrl_t;

    // INFO DR: ctrl[4:0], wstrb[8:5], data_wr[40:9], addr[72:41].
    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data_wr;
        logic [3:0]       wstrb;
        s_axi_jtag_ctrl_t ctrl;
    } s_axi_jtag_info_t;

    // STATUS DR: status[3:0], data_rd[35:4].
    typedef struct packed {
        logic [31:0]      data_rd;
        axi_jtag_status_e status;
    } s_axi_jtag_status_t;

endpackage

// File: rtl/jtag_axi_data_reg.sv
// JTAG data registers for the AXI bridge: one shared shift register serves
// the 73-bit INFO DR (descriptor load / read-back) and the 36-bit STATUS DR.
module jtag_axi_data_reg
    import jtag_axi_pkg::*;
(
    input  logic               tck,
    input  logic               trstn,
    input  logic               tdi,
    output logic               tdo_o,
    input  logic               capture_dr_i,
    input  logic               shift_dr_i,
    input  logic               update_dr_i,
    input  logic               sel_info_i,
    input  logic               sel_status_i,
    output s_axi_jtag_info_t   axi_info_o,
    output logic               axi_req_new_o,
    input  s_axi_jtag_status_t jtag_status_i,
    output logic               axi_status_rd_o
);

    localparam int SR_HI_W = JTAG_INFO_DR_W - JTAG_STATUS_DR_W;

    logic [JTAG_INFO_DR_W-1:0] r_sr;
    s_axi_jtag_info_t          r_info;
    logic                      r_req_new;
    logic                      r_status_rd;
    logic                      w_dr_sel;

    assign w_dr_sel = sel_info_i | sel_status_i;

    // TAP sequencing: INFO select wins over STATUS, capture > shift > update.
    // Pulses default low each cycle so back-to-back updates give separate pulses.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            r_sr        <= '0;
            r_info      <= '0;
            r_req_new   <= 1'b0;
            r_status_rd <= 1'b0;
        end else begin
            r_req_new   <= 1'b0;
            r_status_rd <= 1'b0;
            if (sel_info_i) begin
                if (capture_dr_i) begin
                    r_sr <= r_info;
                end else if (shift_dr_i) begin
                    r_sr <= {tdi, r_sr[JTAG_INFO_DR_W-1:1]};
                end else if (update_dr_i) begin
                    r_info    <= s_axi_jtag_info_t'(r_sr);
                    r_req_new <= r_sr[0];
                end
            end else if (sel_status_i) begin
                if (capture_dr_i) begin
                    // Every status capture pops the response FIFO; the
                    // dispatch stage ignores pops when it is empty.
                    r_sr        <= {{SR_HI_W{1'b0}}, jtag_status_i};
                    r_status_rd <= 1'b1;
                end else if (shift_dr_i) begin
                    r_sr[JTAG_STATUS_DR_W-1:0] <= {tdi, r_sr[JTAG_STATUS_DR_W-1:1]};
                end
            end
        end
    end

    assign tdo_o           = w_dr_sel ? r_sr[0] : 1'b0;
    assign axi_info_o      = r_info;
    assign axi_req_new_o   = r_req_new;
    assign axi_status_rd_o = r_status_rd;

endmodule

// File: tb/tb_jtag_axi_data_reg.sv
// Scoreboard bench for jtag_axi_data_reg: stimulus pushes expected tdo bits,
// request descriptors and FIFO pops; a negedge monitor consumes them.
module tb_jtag_axi_data_reg;
    import jtag_axi_pkg::*;

    logic               tck = 1'b0;
    logic               trstn;
    logic               tdi;
    logic               tdo_o;
    logic               capture_dr_i, shift_dr_i, update_dr_i;
    logic               sel_info_i, sel_status_i;
    s_axi_jtag_info_t   axi_info_o;
    logic               axi_req_new_o;
    s_axi_jtag_status_t jtag_status_i;
    logic               axi_status_rd_o;

    jtag_axi_data_reg dut (
        .tck            (tck),
        .trstn          (trstn),
        .tdi            (tdi),
        .tdo_o          (tdo_o),
        .capture_dr_i   (capture_dr_i),
        .shift_dr_i     (shift_dr_i),
        .update_dr_i    (update_dr_i),
        .sel_info_i     (sel_info_i),
        .sel_status_i   (sel_status_i),
        .axi_info_o     (axi_info_o),
        .axi_req_new_o  (axi_req_new_o),
        .jtag_status_i  (jtag_status_i),
        .axi_status_rd_o(axi_status_rd_o)
    );

    always #5 tck = ~tck;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues
    logic        tdo_q[$];
    logic [72:0] req_q[$];
    int          exp_pops = 0;

    // Reference model: descriptor currently held, and what the DR would load on update
    logic [72:0] cur_info = '0;
    logic [72:0] pending  = '0;

    task automatic check(input string nm, input logic [72:0] act, input logic [72:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [72:0] pack_info(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] wstrb, input logic [2:0] size,
                                              input logic typ, input logic start);
        logic [72:0] v;
        v = 73'(start) | (73'(typ) << 1) | (73'(size) << 2) | (73'(wstrb) << 5)
          | (73'(data) << 9) | (73'(addr) << 41);
        return v;
    endfunction

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic capture_info();
        sel_info_i = 1'b1; sel_status_i = 1'b0;
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        for (int i = 0; i < 73; i++) tdo_q.push_back(cur_info[i]);
        pending = cur_info;
    endtask

    task automatic shift_info(input logic [72:0] v, input int nbits);
        sel_info_i = 1'b1; sel_status_i = 1'b0;
        shift_dr_i = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tdi = v[i];
            tick();
        end
        shift_dr_i = 1'b0;
        if (nbits == 73) pending = v;
    endtask

    task automatic update_info(input int times);
        sel_info_i = 1'b1; sel_status_i = 1'b0;
        update_dr_i = 1'b1;
        for (int i = 0; i < times; i++) begin
            if (pending[0]) req_q.push_back(pending);
            tick();
        end
        update_dr_i = 1'b0;
        cur_info = pending;
        @(negedge tck);
        check("info_after_update", axi_info_o, cur_info);
        #1;
    endtask

    task automatic status_read(input logic [3:0] st, input logic [31:0] d);
        logic [35:0] v;
        sel_info_i = 1'b0; sel_status_i = 1'b1;
        jtag_status_i.data_rd = d;
        jtag_status_i.status  = axi_jtag_status_e'(st);
        v = 36'(st) | (36'(d) << 4);
        capture_dr_i = 1'b1;
        exp_pops++;
        tick();
        capture_dr_i = 1'b0;
        for (int i = 0; i < 36; i++) tdo_q.push_back(v[i]);
        shift_dr_i = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tdi = 1'($urandom_range(0, 1));
            tick();
        end
        shift_dr_i = 1'b0;
        sel_status_i = 1'b0;
    endtask

    // Monitor: compare serial output, request pulses and FIFO pops
    initial begin
        logic        b;
        logic [72:0] e;
        forever begin
            @(negedge tck);
            if (trstn) begin
                if (shift_dr_i && !capture_dr_i && (sel_info_i || sel_status_i)) begin
                    if (tdo_q.size() == 0) begin
                        check("tdo_unexpected_shift", 73'(tdo_o), 73'(1'bx));
                    end else begin
                        b = tdo_q.pop_front();
                        check("tdo_bit", 73'(tdo_o), 73'(b));
                    end
                end
                if (axi_req_new_o) begin
                    if (req_q.size() == 0) begin
                        check("req_new_unexpected", 73'(axi_req_new_o), 73'(0));
                    end else begin
                        e = req_q.pop_front();
                        check("req_descriptor", axi_info_o, e);
                    end
                end
                if (axi_status_rd_o) begin
                    check("status_rd_pulse_expected", 73'(exp_pops > 0), 73'(1));
                    if (exp_pops > 0) exp_pops--;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [72:0] v;
        tdi = 0; capture_dr_i = 0; shift_dr_i = 0; update_dr_i = 0;
        sel_info_i = 0; sel_status_i = 0; jtag_status_i = '0;
        trstn = 1'b0;
        #2;
        check("reset_info", axi_info_o, 73'(0));
        check("reset_req_new", 73'(axi_req_new_o), 73'(0));
        check("reset_status_rd", 73'(axi_status_rd_o), 73'(0));
        check("reset_tdo", 73'(tdo_o), 73'(0));
        repeat (2) @(negedge tck);
        trstn = 1'b1;
        tick();

        // Update straight out of reset loads zero and issues no request
        update_info(1);

        // Directed write descriptor
        capture_info();
        v = pack_info(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 1'b1, 1'b1);
        shift_info(v, 73);
        update_info(1);

        // tdo is 0 with no DR selected, even though sr[0] is 1
        sel_info_i = 1'b0; sel_status_i = 1'b0;
        #1;
        check("tdo_no_select", 73'(tdo_o), 73'(0));

        // No select: capture/update must not touch the descriptor
        capture_dr_i = 1'b1; tick(); capture_dr_i = 1'b0;
        update_dr_i = 1'b1; tick(); update_dr_i = 1'b0;
        @(negedge tck);
        check("info_hold_no_select", axi_info_o, cur_info);
        #1;

        // start = 0: descriptor loads, no request
        capture_info();
        v = pack_info(32'h0000_1234, 32'hCAFE_F00D, 4'h3, 3'd1, 1'b0, 1'b0);
        shift_info(v, 73);
        update_info(1);

        // Read-back of the current descriptor while shifting zeros
        capture_info();
        shift_info(73'(0), 73);

        // Status read
        status_read(4'(OKAY), 32'h1234_5678);

        // Dual select: INFO wins, no FIFO pop
        sel_info_i = 1'b1; sel_status_i = 1'b1;
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        for (int i = 0; i < 73; i++) tdo_q.push_back(cur_info[i]);
        sel_status_i = 1'b0;
        v = pack_info($urandom, $urandom, 4'($urandom), 3'($urandom), 1'b1, 1'b1);
        shift_info(v, 73);
        update_info(1);

        // Reset in the middle of an INFO shift
        capture_info();
        shift_info(pack_info($urandom, $urandom, 4'hF, 3'd2, 1'b1, 1'b1), 40);
        tdo_q.delete();
        #2;
        trstn = 1'b0;
        #1;
        check("midshift_reset_info", axi_info_o, 73'(0));
        check("midshift_reset_req_new", 73'(axi_req_new_o), 73'(0));
        check("midshift_reset_status_rd", 73'(axi_status_rd_o), 73'(0));
        check("midshift_reset_tdo", 73'(tdo_o), 73'(0));
        cur_info = '0;
        pending  = '0;
        @(negedge tck);
        trstn = 1'b1;
        tick();
        update_info(1);

        // Randomized traffic, including back-to-back updates
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) != 3) begin
                capture_info();
                v = pack_info($urandom, $urandom, 4'($urandom), 3'($urandom),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                shift_info(v, 73);
                update_info($urandom_range(1, 2));
            end else begin
                status_read(4'($urandom_range(0, 10)), $urandom);
            end
        end

        // Drain and confirm every expected event was seen
        sel_info_i = 1'b0; sel_status_i = 1'b0;
        repeat (3) tick();
        check("tdo_queue_drained", 73'(tdo_q.size()), 73'(0));
        check("req_queue_drained", 73'(req_q.size()), 73'(0));
        check("pops_all_seen", 73'(exp_pops), 73'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_axi_data_reg.md
JTAG_AXI_DATA_REG -- requirements
Module: jtag_axi_data_reg

Interface
REQ-001 The block SHALL have one clock, tck, and an asynchronous active-low reset, trstn; no other clock or reset exists.
REQ-002 Port tck, input, 1 bit: JTAG test clock; all state updates on its rising edge.
REQ-003 Port trstn, input, 1 bit: asynchronous active-low reset.
REQ-004 Port tdi, input, 1 bit: serial data in.
REQ-005 Port tdo_o, output, 1 bit: serial data out; combinational from the shift register LSB when a DR is selected, else 0.
REQ-006 Port capture_dr_i, input, 1 bit: TAP is in Capture-DR.
REQ-007 Port shift_dr_i, input, 1 bit: TAP is in Shift-DR.
REQ-008 Port update_dr_i, input, 1 bit: TAP is in Update-DR.
REQ-009 Port sel_info_i, input, 1 bit: IR selects the INFO DR (73 bits).
REQ-010 Port sel_status_i, input, 1 bit: IR selects the STATUS DR (36 bits).
REQ-011 Port axi_info_o, output, s_axi_jtag_info_t (73 bits): registered transaction descriptor for the dispatch stage.
REQ-012 Port axi_req_new_o, output, 1 bit: one-tck pulse; a new descriptor has been loaded.
REQ-013 Port jtag_status_i, input, s_axi_jtag_status_t (36 bits): current status from the dispatch stage.
REQ-014 Port axi_status_rd_o, output, 1 bit: one-tck pulse popping the response FIFO.

Function
REQ-015 The INFO layout SHALL be, LSB first: ctrl.start[0], ctrl.txn_type[1] (1 = write), ctrl.size[4:2], wstrb[8:5], data_wr[40:9], addr[72:41].
REQ-016 The STATUS layout SHALL be, LSB first: status[3:0], data_rd[35:4].
REQ-017 A 73-bit shift register sr SHALL serve both DRs; STATUS uses sr[35:0].
REQ-018 Capture-DR with sel_info SHALL load sr with the current axi_info_o, giving read-back.
REQ-019 Capture-DR with sel_status SHALL load sr[35:0] with jtag_status_i and clear sr[72:36].
REQ-020 Capture-DR with sel_status SHALL also pulse axi_status_rd_o high for exactly that one tck cycle, regardless of the status value; the dispatch stage guards pops against an empty FIFO.
REQ-021 Shift-DR with sel_info SHALL perform sr <= {tdi, sr[72:1]}.
REQ-022 Shift-DR with sel_status SHALL perform sr[35:0] <= {tdi, sr[35:1]}; sr[72:36] SHALL be held.
REQ-023 Update-DR with sel_info SHALL load axi_info_o <= sr in that cycle.
REQ-024 In that Update-DR cycle, axi_req_new_o SHALL pulse high for one cycle if and only if sr[0] (start) = 1.
REQ-025 Update-DR with sel_status SHALL have no effect.
REQ-026 With neither select asserted, sr, axi_info_o and all pulses SHALL be held or at 0, and tdo_o = 0.
REQ-027 If both selects are high, sel_info SHALL take priority.
REQ-028 If more than one TAP state input is high, the priority SHALL be capture > shift > update.
REQ-029 axi_info_o SHALL change only on Update-DR with sel_info; a descriptor is never partially updated.
REQ-030 Back-to-back updates SHALL each produce their own pulse; no pulse merging occurs.

Reset
REQ-031 Asserting trstn low SHALL immediately clear sr, axi_info_o, axi_req_new_o and axi_status_rd_o to 0, including mid-shift.
REQ-032 After deassertion, the first Update-DR without a preceding complete shift SHALL load the reset contents of sr (start = 0), so no request is issued.

Structure
REQ-033 The DR widths (JTAG_INFO_DR_W = 73, JTAG_STATUS_DR_W = 36) SHALL be defined in jtag_axi_pkg.
REQ-034 The status enum SHALL be defined in jtag_axi_pkg: IDLE, RUNNING, OKAY, EXOKAY, SLVERR, DECERR, TIMEOUT_AW/AR/W/B/R, 4 bits.
REQ-035 s_axi_jtag_info_t and s_axi_jtag_status_t SHALL be defined in jtag_axi_pkg.
REQ-036 The block SHALL be flat, with no sub-module.

Verification
REQ-037 Write descriptor: shift 73 bits with addr=0x8000_0010, data=0xDEAD_BEEF, wstrb=0xF, size=2, txn_type=1, start=1, then update -> axi_info_o matches and axi_req_new_o is high for exactly 1 cycle.
REQ-038 Start=0: shift a descriptor with start=0, then update -> axi_info_o is updated and axi_req_new_o stays 0.
REQ-039 Read-back: capture INFO, then shift 73 zeros -> tdo_o streams the previous descriptor LSB first.
REQ-040 Status read: drive jtag_status_i={data_rd=0x1234_5678, status=OKAY}, capture STATUS, shift 36 bits -> axi_status_rd_o pulses once, and tdo_o returns the status nibble followed by 0x1234_5678.
REQ-041 Reset mid-shift: assert trstn after 40 INFO shift bits -> all outputs are 0 immediately; a subsequent update issues no request.
REQ-042 Dual select: assert sel_info and sel_status together during capture -> INFO is captured and axi_status_rd_o stays 0.
